// File: rtl/m65c02_pfx_rdsel.sv
// rtl/m65c02_pfx_rdsel.sv - OAX/OAY/OSY prefix sequencer and ALU read-operand selector
//
// This block tracks the register-override prefixes (OAX, OAY, OSY) as they are
// loaded into IR. It holds them pending until the next non-prefix opcode
// arrives, applies them for the whole of that instruction, and then clears them.
// It also produces a registered one-hot ALU read select. That select is built
// with the same swap rules as the overrides.
//
// Optional build macro: M65C02_PFX_ERR_EN adds the sticky Pfx_Err output.
//
// Ports:
//   Rst      async active-high reset
//   Clk      system clock, rising edge
//   Rdy      microcycle enable; all state holds when low
//   IR_Ld    opcode load strobe (IR valid this cycle)
//   IR       opcode being loaded
//   Done     last microcycle of the current instruction
//   Int      interrupt/BRK entry; flushes prefixes (highest priority)
//   RSel     microword read-operand select
//   OAX/OAY/OSY  override lines for the register write-select logic
//   IntInh   inhibit interrupt recognition while a prefix is pending
//   RdA..RdP registered one-hot ALU read selects
//   Pfx_Err  sticky conflicting-prefix flag (M65C02_PFX_ERR_EN only)

module m65c02_pfx_rdsel #(
  parameter logic [7:0] OAX_OP = 8'hFB,
  parameter logic [7:0] OAY_OP = 8'hEB,
  parameter logic [7:0] OSY_OP = 8'h9B
) (
  input  logic       Rst,
  input  logic       Clk,
  input  logic       Rdy,
  input  logic       IR_Ld,
  input  logic [7:0] IR,
  input  logic       Done,
  input  logic       Int,
  input  logic [2:0] RSel,
  output logic       OAX,
  output logic       OAY,
  output logic       OSY,
  output logic       IntInh,
  output logic       RdA,
  output logic       RdX,
  output logic       RdY,
  output logic       RdS,
`ifdef M65C02_PFX_ERR_EN
  output logic       RdP,
  output logic       Pfx_Err
`else
  output logic       RdP
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, ACTV = 2'd2} state_t;

  state_t state, nxt_state;
  logic   p_x, p_y, p_s;
  logic   nxt_px, nxt_py, nxt_ps;
  logic   nxt_oax, nxt_oay, nxt_osy;

  logic is_oax, is_oay, is_osy, is_pfx;

  assign is_oax = (IR == OAX_OP);
  assign is_oay = (IR == OAY_OP);
  assign is_osy = (IR == OSY_OP);
  assign is_pfx = is_oax | is_oay | is_osy;

  // The IDLE term closes the one-cycle window in which the first prefix is
  // being loaded but the state has not yet reached PEND.
  assign IntInh = (state == PEND) | ((state == IDLE) & IR_Ld & is_pfx);

`ifdef M65C02_PFX_ERR_EN
  logic nxt_err;
`endif

  always_comb begin
    nxt_state = state;
    nxt_px    = p_x;
    nxt_py    = p_y;
    nxt_ps    = p_s;
    nxt_oax   = OAX;
    nxt_oay   = OAY;
    nxt_osy   = OSY;
`ifdef M65C02_PFX_ERR_EN
    nxt_err   = Pfx_Err;
`endif
    if (Int) begin
      nxt_state = IDLE;
      nxt_px    = 1'b0;
      nxt_py    = 1'b0;
      nxt_ps    = 1'b0;
      nxt_oax   = 1'b0;
      nxt_oay   = 1'b0;
      nxt_osy   = 1'b0;
`ifdef M65C02_PFX_ERR_EN
      nxt_err   = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (IR_Ld && is_pfx) begin
            nxt_px    = is_oax;
            nxt_py    = is_oay;
            nxt_ps    = is_osy;
            nxt_state = PEND;
          end
        end
        PEND: begin
          if (IR_Ld) begin
            if (is_pfx) begin
              // Last prefix wins. OAY excludes both OAX and OSY.
              // OAX and OSY touch disjoint register pairs, so they may stack.
              if (is_oax) begin
                nxt_px = 1'b1;
                nxt_py = 1'b0;
              end
              if (is_oay) begin
                nxt_py = 1'b1;
                nxt_px = 1'b0;
                nxt_ps = 1'b0;
              end
              if (is_osy) begin
                nxt_ps = 1'b1;
                nxt_py = 1'b0;
              end
`ifdef M65C02_PFX_ERR_EN
              if ((is_oax & p_y) | (is_oay & (p_x | p_s)) | (is_osy & p_y))
                nxt_err = 1'b1;
`endif
            end else begin
              nxt_oax   = p_x;
              nxt_oay   = p_y;
              nxt_osy   = p_s;
              nxt_px    = 1'b0;
              nxt_py    = 1'b0;
              nxt_ps    = 1'b0;
              nxt_state = ACTV;
            end
          end
        end
        ACTV: begin
          if (Done) begin
            nxt_oax = 1'b0;
            nxt_oay = 1'b0;
            nxt_osy = 1'b0;
            if (IR_Ld && is_pfx) begin
              nxt_px    = is_oax;
              nxt_py    = is_oay;
              nxt_ps    = is_osy;
              nxt_state = PEND;
            end else begin
              nxt_state = IDLE;
            end
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_px    = 1'b0;
          nxt_py    = 1'b0;
          nxt_ps    = 1'b0;
          nxt_oax   = 1'b0;
          nxt_oay   = 1'b0;
          nxt_osy   = 1'b0;
        end
      endcase
    end
  end

  // Read-select decode. It uses the post-edge override values, so the select
  // registered on the target's load edge is already swapped.
  logic       l_a, l_x, l_y, l_s, l_p;
  logic [4:0] nxt_rd;

  always_comb begin
    l_a = (RSel == 3'b011);
    l_x = (RSel == 3'b001);
    l_y = (RSel == 3'b010);
    l_p = (RSel == 3'b100);
    l_s = (RSel == 3'b101);
    nxt_rd[4] = (l_a & ~nxt_oax & ~nxt_oay) | (l_x & nxt_oax) | (l_y & nxt_oay);
    nxt_rd[3] = (l_x & ~nxt_oax) | (l_a & nxt_oax);
    nxt_rd[2] = (l_y & ~nxt_oay & ~nxt_osy) | (l_a & nxt_oay) | (l_s & nxt_osy);
    nxt_rd[1] = (l_s & ~nxt_osy) | (l_y & nxt_osy);
    nxt_rd[0] = l_p;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      p_x   <= 1'b0;
      p_y   <= 1'b0;
      p_s   <= 1'b0;
      OAX   <= 1'b0;
      OAY   <= 1'b0;
      OSY   <= 1'b0;
      {RdA, RdX, RdY, RdS, RdP} <= 5'b0;
`ifdef M65C02_PFX_ERR_EN
      Pfx_Err <= 1'b0;
`endif
    end else if (Rdy) begin
      state <= nxt_state;
      p_x   <= nxt_px;
      p_y   <= nxt_py;
      p_s   <= nxt_ps;
      OAX   <= nxt_oax;
      OAY   <= nxt_oay;
      OSY   <= nxt_osy;
      {RdA, RdX, RdY, RdS, RdP} <= nxt_rd;
`ifdef M65C02_PFX_ERR_EN
      Pfx_Err <= nxt_err;
`endif
    end
  end

endmodule

// File: tb/tb_m65c02_pfx_rdsel.sv
// tb/tb_m65c02_pfx_rdsel.sv - directed self-checking bench for m65c02_pfx_rdsel

module tb_m65c02_pfx_rdsel;

  logic       Rst, Clk, Rdy, IR_Ld, Done, Int;
  logic [7:0] IR;
  logic [2:0] RSel;
  logic       OAX, OAY, OSY, IntInh, RdA, RdX, RdY, RdS, RdP;
`ifdef M65C02_PFX_ERR_EN
  logic       Pfx_Err;
`endif

  int checks = 0;
  int failures = 0;

  m65c02_pfx_rdsel dut (
    .Rst(Rst), .Clk(Clk), .Rdy(Rdy), .IR_Ld(IR_Ld), .IR(IR), .Done(Done),
    .Int(Int), .RSel(RSel), .OAX(OAX), .OAY(OAY), .OSY(OSY), .IntInh(IntInh),
    .RdA(RdA), .RdX(RdX), .RdY(RdY), .RdS(RdS),
`ifdef M65C02_PFX_ERR_EN
    .RdP(RdP), .Pfx_Err(Pfx_Err)
`else
    .RdP(RdP)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Rd vector order: {A,X,Y,S,P}
  localparam logic [4:0] R_A = 5'b10000, R_X = 5'b01000, R_Y = 5'b00100,
                         R_S = 5'b00010, R_P = 5'b00001, R_0 = 5'b00000;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic ld, input logic [7:0] op, input logic [2:0] rs);
    IR_Ld = ld;
    IR    = op;
    RSel  = rs;
  endtask

  function automatic logic [7:0] ovr();
    return {5'b0, OAX, OAY, OSY};
  endfunction

  function automatic logic [7:0] rd();
    return {3'b0, RdA, RdX, RdY, RdS, RdP};
  endfunction

  initial begin
    Rst = 1'b1; Rdy = 1'b1; Done = 1'b0; Int = 1'b0;
    load(1'b0, 8'h00, 3'b000);
    tick(); tick();
    check("rst_ovr", ovr(), 8'h00);
    check("rst_rd", rd(), 8'h00);
    check("rst_inh", {7'b0, IntInh}, 8'h00);
    Rst = 1'b0;
    tick();

    // OAX prefix then LDA#: A and X swap for the target instruction.
    load(1'b1, 8'hFB, 3'b000); #1;
    check("t1_inh_idle", {7'b0, IntInh}, 8'h01);
    tick();
    load(1'b1, 8'hA9, 3'b011); #1;
    check("t1_inh_pend", {7'b0, IntInh}, 8'h01);
    tick();
    check("t1_ovr", ovr(), 8'h04);
    check("t1_rd_a2x", rd(), {3'b0, R_X});
    load(1'b0, 8'hA9, 3'b001);
    tick();
    check("t1_rd_x2a", rd(), {3'b0, R_A});
    Done = 1'b1; RSel = 3'b011;
    tick();
    Done = 1'b0;
    check("t1_ovr_clr", ovr(), 8'h00);
    check("t1_rd_plain", rd(), {3'b0, R_A});

    // OSY then OAX stack onto PHA.
    load(1'b1, 8'h9B, 3'b000); tick();
    load(1'b1, 8'hFB, 3'b000); tick();
    load(1'b1, 8'h48, 3'b101); tick();
    check("t2_ovr", ovr(), 8'h05);
    check("t2_rd_s2y", rd(), {3'b0, R_Y});
    load(1'b0, 8'h48, 3'b010); tick();
    check("t2_rd_y2s", rd(), {3'b0, R_S});
    RSel = 3'b100; tick();
    check("t2_rd_p", rd(), {3'b0, R_P});
    RSel = 3'b110; tick();
    check("t2_rd_mem", rd(), {3'b0, R_0});
    Done = 1'b1; tick(); Done = 1'b0;
    check("t2_ovr_clr", ovr(), 8'h00);

    // OAX then OAY: the later prefix wins.
    load(1'b1, 8'hFB, 3'b000); tick();
    load(1'b1, 8'hEB, 3'b000); tick();
    load(1'b1, 8'hEA, 3'b011); tick();
    check("t3_ovr", ovr(), 8'h02);
    check("t3_rd_a2y", rd(), {3'b0, R_Y});
`ifdef M65C02_PFX_ERR_EN
    check("t3_err", {7'b0, Pfx_Err}, 8'h01);
`endif
    load(1'b0, 8'h00, 3'b000);
    Done = 1'b1; tick(); Done = 1'b0;
    check("t3_ovr_clr", ovr(), 8'h00);
`ifdef M65C02_PFX_ERR_EN
    check("t3_err_sticky", {7'b0, Pfx_Err}, 8'h01);
    Int = 1'b1; tick(); Int = 1'b0;
    check("t3_err_int", {7'b0, Pfx_Err}, 8'h00);
`endif

    // Int arrives on the target load edge and wins.
    load(1'b1, 8'hEB, 3'b000); tick();
    load(1'b1, 8'hA9, 3'b011); Int = 1'b1; tick();
    Int = 1'b0; load(1'b0, 8'h00, 3'b011); #1;
    check("t4_ovr", ovr(), 8'h00);
    check("t4_inh", {7'b0, IntInh}, 8'h00);
    load(1'b1, 8'hA9, 3'b011); tick();
    check("t4_no_pfx", ovr(), 8'h00);
    check("t4_rd", rd(), {3'b0, R_A});
    load(1'b0, 8'h00, 3'b000);
    Done = 1'b1; tick(); Done = 1'b0;

    // Rdy low while PEND: everything holds and the EB load is ignored.
    load(1'b1, 8'hFB, 3'b011); tick();
    check("t5_rd_pre", rd(), {3'b0, R_A});
    Rdy = 1'b0;
    load(1'b1, 8'hEB, 3'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_inh", {7'b0, IntInh}, 8'h01);
      check("t5_hold_ovr", ovr(), 8'h00);
      check("t5_hold_rd", rd(), {3'b0, R_A});
    end
    Rdy = 1'b1;
    load(1'b1, 8'hEA, 3'b011); tick();
    check("t5_resume_ovr", ovr(), 8'h04);
    check("t5_resume_rd", rd(), {3'b0, R_X});

    // Done coinciding with a new prefix goes straight to PEND with that bit only.
    load(1'b0, 8'h00, 3'b000);
    Done = 1'b1; tick(); Done = 1'b0;
    load(1'b1, 8'hEB, 3'b000); tick();
    load(1'b1, 8'hEA, 3'b000); tick();
    check("t6_oay", ovr(), 8'h02);
    load(1'b1, 8'hFB, 3'b000); Done = 1'b1; tick(); Done = 1'b0;
    load(1'b0, 8'h00, 3'b000); #1;
    check("t6_pend_ovr", ovr(), 8'h00);
    check("t6_pend_inh", {7'b0, IntInh}, 8'h01);
    load(1'b1, 8'hA9, 3'b011); tick();
    check("t6_new_ovr", ovr(), 8'h04);
    check("t6_new_rd", rd(), {3'b0, R_X});

    // Asynchronous reset while ACTV with OAX set.
    load(1'b0, 8'h00, 3'b011);
    Rst = 1'b1; #1;
    check("t7_rst_ovr", ovr(), 8'h00);
    check("t7_rst_rd", rd(), 8'h00);
    #1 Rst = 1'b0;
    tick();
    check("t7_post_ovr", ovr(), 8'h00);
    check("t7_post_rd", rd(), {3'b0, R_A});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m65c02_pfx_rdsel.md
Name: m65c02_pfx_rdsel

Overview:
- Prefix sequencer and ALU read-operand selector for the M65C02A core.
- Tracks the OAX, OAY and OSY register-override prefix opcodes as they are loaded into IR, and holds them pending until the next non-prefix instruction.
- Applies the overrides for the whole of that instruction, then clears them.
- Drives the OAX/OAY/OSY override lines used by the register write-select logic, plus a registered one-hot read select (A, X, Y, S, P) for the ALU operand mux, using the same swap rules.

Parameters:
- OAX_OP, 8'hFB, opcode of the OAX prefix (swap A and X).
- OAY_OP, 8'hEB, opcode of the OAY prefix (swap A and Y).
- OSY_OP, 8'h9B, opcode of the OSY prefix (swap Y and S).

Ports:
- Rst  input  1  reset. Asynchronous, active-high.
- Clk  input  1  system clock. All state updates on the rising edge.
- Rdy  input  1  microcycle enable. No state changes when low.
- IR_Ld  input  1  opcode load strobe. IR is valid this cycle.
- IR  input  8  opcode being loaded.
- Done  input  1  last microcycle of the current instruction.
- Int  input  1  interrupt/BRK sequence entered. Flushes prefixes.
- RSel  input  3  read operand select from the microword.
- OAX  output  1  A/X swap active.
- OAY  output  1  A/Y swap active.
- OSY  output  1  Y/S swap active.
- IntInh  output  1  inhibit interrupt recognition (prefix pending).
- RdA, RdX, RdY, RdS, RdP  output  1 each  registered one-hot ALU read selects.
- Pfx_Err  output  1  conflicting-prefix status. Present only with the optional feature.

Behaviour:
- Reset: all outputs 0, state IDLE, pending bits {pX,pY,pS}=0.
- Updates are qualified by Rdy. With Rdy=0, every register holds.
- States:
  - IDLE: no overrides.
  - PEND: at least one prefix captured; target not yet loaded.
  - ACTV: overrides applied to the target instruction.
- IDLE, IR_Ld with a prefix opcode: set the matching pending bit, go to PEND.
- PEND, IR_Ld with a prefix opcode: merge into the pending bits.
  - OAX and OAY are mutually exclusive; the later one clears the other.
  - OSY and OAY are mutually exclusive; the later one clears the other.
  - OAX and OSY may combine.
  - A repeated identical prefix is idempotent.
- PEND, IR_Ld with a non-prefix opcode: copy pending bits to OAX/OAY/OSY in the same edge, go to ACTV.
- ACTV, Done: clear OAX/OAY/OSY, go to IDLE.
  - If IR_Ld with a prefix opcode coincides with Done: go to PEND with only the new bit set.
- IntInh = 1 in PEND, so no interrupt can split a prefix from its target.
  - IntInh is also 1 in the cycle IR_Ld loads a prefix from IDLE (combinational on IR decode).
- Int in any state: clear all pending bits and overrides, go to IDLE. Int has priority over IR_Ld and Done in the same cycle.
- Read-select decode of RSel:
  - 000 none; 001 X; 010 Y; 011 A; 100 P; 101 S; 110 memory (no register); 111 none.
  - Swaps use the override values in effect after the edge. OAX: A<->X. OAY: A<->Y. OSY: Y<->S.
  - OAX and OSY together: logical A reads X, X reads A, Y reads S, S reads Y.
  - P is never swapped.
- Rd* outputs are registered: 1-cycle latency from RSel. At most one Rd* is high at a time.
- Reset asserted mid-instruction forces IDLE immediately. Selects go to 0 asynchronously.

Optional Feature:
- Macro: M65C02_PFX_ERR_EN.
- With it: Pfx_Err is a sticky flag, set when a conflicting prefix overrides an earlier one (OAX/OAY or OSY/OAY) while in PEND.
  - Cleared only by Rst or by Int.
- Without it: the Pfx_Err port and its logic are absent. Conflict resolution (last wins) is unchanged.

Test Plan:
- IR=FB (IR_Ld), then IR=A9 (IR_Ld) -> IntInh=1 for both cycles; OAX=1 from the A9 load until Done. RSel=011 gives RdX=1; RSel=001 gives RdA=1. OAX=0 the cycle after Done.
- IR=9B, then IR=FB, then IR=48 -> OSY=1 and OAX=1 for 48. RSel=101 gives RdY=1; RSel=010 gives RdS=1; RSel=100 gives RdP=1.
- IR=FB, then IR=EB, then IR=EA -> OAY=1, OAX=0. With M65C02_PFX_ERR_EN, Pfx_Err=1 and it stays 1 until Int.
- IR=EB loaded, then Int=1 in the same cycle as the target IR_Ld -> OAY stays 0, state IDLE, IntInh=0 next cycle.
- Rdy=0 for 3 cycles while in PEND -> pending bits and outputs held. Capture resumes correctly when Rdy=1.
- Rst asserted while in ACTV with OAX=1 -> all outputs 0 asynchronously. After release, RSel=011 gives RdA=1.
